pid_error_gen: RTL and testbench
================================

Name: pid_error_gen

Overview:
Front end of the assist control loop. It conditions the crank cadence pulse, the torque sample and the motor current sample, and computes a target current from torque, cadence and assist level. It then produces the signed error and not_pedaling inputs that the PID controller consumes. It sits between the ADC/sensor interface and the PID block.

Parameters:
FAST_SIM, 0, nonzero shortens the cadence measurement window from 2^22 to 2^12 clocks for simulation.
TORQUE_MIN, 12'h380, torque dead-band; averaged torque at or below this value gives zero target.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
cadence_raw  input  1  asynchronous crank sensor pulse
torque  input  12  unsigned torque sample
torque_vld  input  1  one-cycle strobe; torque is valid this cycle
curr  input  12  unsigned motor current sample
curr_vld  input  1  one-cycle strobe; curr is valid this cycle
scale  input  3  assist level, 0 = off, 7 = max
batt  input  12  battery voltage sample (used only with the optional feature)
error  output  13  signed target_curr - avg_curr, registered
not_pedaling  output  1  registered; high when cadence is too low
target_curr  output  12  registered target current

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: error = 0, not_pedaling = 1, target_curr = 0. All accumulators, counters and sync flops clear to 0. Reset mid-operation discards the window in progress.
- Cadence sync: cadence_raw passes through a 2-flop synchronizer and then a third flop. A rising edge is sync2 & ~sync3. Because the flops reset to 0, a high input at reset release counts as one edge.
- Window counter: free-running, 22 bits (12 bits with FAST_SIM). Window end is the all-ones value.
- Edge counter: 5 bits, saturates at 31. At window end, cadence_rate <= edge count + (edge this cycle, saturating), and the counter restarts at 0. An edge in the window-end cycle is counted in the closing window, not the new one.
- not_pedaling: registered, equal to (cadence_rate < 2). It updates the cycle after cadence_rate changes.
- Torque average: 16-bit accumulator. On torque_vld, acc <= acc - (acc>>4) + torque. torque_avg = acc[15:4]. Steady input T gives torque_avg = T.
- Current average: 14-bit accumulator. On curr_vld, acc <= acc - (acc>>2) + curr. avg_curr = acc[13:2].
- Strobes never occur when not asserted; both strobes may occur in the same cycle, and each is handled independently.
- Target, registered every cycle:
  - 0 if not_pedaling, or torque_avg <= TORQUE_MIN, or scale = 0.
  - Otherwise prod = (torque_avg - TORQUE_MIN) * cadence_rate * scale, 20 bits unsigned (maximum 888,615, no overflow), and target_curr = prod[19:8].
- Error, registered every cycle: error <= {1'b0,target_curr} - {1'b0,avg_curr}, 13-bit signed.
  - Range is -4095..+4095; no saturation is needed.
  - Latency from a curr_vld sample to error is 2 clocks (accumulator, then error register).

Optional Feature:
Macro LOW_BATT_CUTOFF_EN.
- When defined: target_curr is forced to 0 while batt < 12'hA98. This uses a registered compare with 8 LSB of hysteresis, releasing at batt >= 12'hAA0. The compare flop resets to "cutoff active".
- When undefined: batt is ignored and no cutoff logic is built.

Decomposition:
Package ebike_pkg holds:
- TORQUE_MIN default value
- the cadence window widths (22 and 12)
- the battery thresholds 12'hA98 and 12'hAA0
- a typedef for the 12-bit unsigned sample type
- a typedef for the 13-bit signed error type

One natural sub-module is exp_avg, parameterised by SHIFT and accumulator width, with ports clk, rst, vld, din, avg. It is instantiated once for torque (SHIFT = 4) and once for current (SHIFT = 2).

Test Plan:
1. Reset: hold rst with all inputs toggling -> error = 0, target_curr = 0, not_pedaling = 1. Release -> not_pedaling stays 1 through the first window.
2. FAST_SIM = 1, cadence period 256 clocks, torque = 12'h780 strobed every 64 clocks, curr = 12'h040 strobed, scale = 4, settled -> cadence_rate = 16, target_curr = 12'h100, error = +192.
3. Same as 2 but curr = 12'h180 -> error = -128.
4. Stop cadence toggling -> not_pedaling = 1 within two windows plus 1 clock; target_curr = 0; error = -avg_curr.
5. torque = 12'h380 (at the dead-band) with pedaling -> target_curr = 0. Edge in the exact window-end cycle counts in the closing window (check rate 16 vs 15).
6. LOW_BATT_CUTOFF_EN: batt = 12'hA90 -> target_curr = 0; batt = 12'hA9C -> still 0 (hysteresis); batt = 12'hAA0 -> target restored to 12'h100.

Source files
------------

// File: rtl/ebike_pkg.sv
// Shared types and constants for the e-bike assist front end.
package ebike_pkg;

  typedef logic [11:0]        sample_t;
  typedef logic signed [12:0] err_t;

  localparam sample_t TORQUE_MIN_DEF = 12'h380;
  localparam int      WIN_W_FULL     = 22;
  localparam int      WIN_W_FAST     = 12;
  localparam sample_t BATT_CUT       = 12'hA98;
  localparam sample_t BATT_REL       = 12'hAA0;

endpackage

// File: rtl/pid_error_gen_exp_avg.sv
// Exponential moving average: acc <= acc - acc/2^SHIFT + din, avg = acc >> SHIFT.
module exp_avg #(
  parameter int DATA_W = 12,
  parameter int ACC_W  = 16,
  parameter int SHIFT  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vld,
  input  logic [DATA_W-1:0]        din,
  output logic [ACC_W-SHIFT-1:0]   avg
);

  logic [ACC_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (vld) acc_d = acc_q - (acc_q >> SHIFT) + {{(ACC_W-DATA_W){1'b0}}, din};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign avg = acc_q[ACC_W-1:SHIFT];

endmodule

// File: rtl/pid_error_gen.sv
// Cadence/torque/current conditioning and PID error generation.
// Optional low-battery cutoff enabled by defining LOW_BATT_CUTOFF_EN.
module pid_error_gen
  import ebike_pkg::*;
#(
  parameter int      FAST_SIM   = 0,
  parameter sample_t TORQUE_MIN = TORQUE_MIN_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cadence_raw,
  input  logic [11:0]        torque,
  input  logic               torque_vld,
  input  logic [11:0]        curr,
  input  logic               curr_vld,
  input  logic [2:0]         scale,
  input  logic [11:0]        batt,
  output logic signed [12:0] error,
  output logic               not_pedaling,
  output logic [11:0]        target_curr
);

  localparam int WIN_W = (FAST_SIM != 0) ? WIN_W_FAST : WIN_W_FULL;

  function automatic logic [4:0] sat_inc5(input logic [4:0] v, input logic inc);
    return (inc && v != 5'd31) ? v + 5'd1 : v;
  endfunction

  logic [2:0]       sync_q;
  logic [WIN_W-1:0] win_q;
  logic [4:0]       edge_cnt_q, rate_q;
  logic             np_q, cadence_edge, win_end, cutoff;
  sample_t          torque_avg, avg_curr, tdiff, target_d, target_q;
  err_t             error_q;
  logic [19:0]      prod;

  exp_avg #(.DATA_W(12), .ACC_W(16), .SHIFT(4)) u_torque_avg (
    .clk(clk), .rst(rst), .vld(torque_vld), .din(torque), .avg(torque_avg)
  );

  exp_avg #(.DATA_W(12), .ACC_W(14), .SHIFT(2)) u_curr_avg (
    .clk(clk), .rst(rst), .vld(curr_vld), .din(curr), .avg(avg_curr)
  );

  assign cadence_edge = sync_q[1] & ~sync_q[2];
  assign win_end      = &win_q;

  // An edge in the window-end cycle belongs to the window that is closing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      win_q      <= '0;
      edge_cnt_q <= '0;
      rate_q     <= '0;
      np_q       <= 1'b1;
    end else begin
      sync_q <= {sync_q[1:0], cadence_raw};
      win_q  <= win_q + WIN_W'(1);
      np_q   <= (rate_q < 5'd2);
      if (win_end) begin
        rate_q     <= sat_inc5(edge_cnt_q, cadence_edge);
        edge_cnt_q <= '0;
      end else begin
        edge_cnt_q <= sat_inc5(edge_cnt_q, cadence_edge);
      end
    end
  end

`ifdef LOW_BATT_CUTOFF_EN
  logic cut_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cut_q <= 1'b1;
    else if (batt < BATT_CUT)  cut_q <= 1'b1;
    else if (batt >= BATT_REL) cut_q <= 1'b0;
  end

  assign cutoff = cut_q;
`else
  logic unused_batt;
  assign unused_batt = ^batt;
  assign cutoff      = 1'b0;
`endif

  assign tdiff = torque_avg - TORQUE_MIN;
  assign prod  = 20'(tdiff) * 20'(rate_q) * 20'(scale);

  always_comb begin
    target_d = 12'(prod >> 8);
    if (np_q || (torque_avg <= TORQUE_MIN) || (scale == 3'd0) || cutoff) target_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q <= '0;
      error_q  <= '0;
    end else begin
      target_q <= target_d;
      error_q  <= $signed({1'b0, target_q}) - $signed({1'b0, avg_curr});
    end
  end

  assign error        = error_q;
  assign not_pedaling = np_q;
  assign target_curr  = target_q;

endmodule

// File: tb/tb_pid_error_gen.sv
// Directed bench for pid_error_gen with FAST_SIM windows of 4096 clocks.
module tb_pid_error_gen;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cadence_raw = 1'b0;
  logic [11:0]        torque = '0;
  logic               torque_vld = 1'b0;
  logic [11:0]        curr = '0;
  logic               curr_vld = 1'b0;
  logic [2:0]         scale = '0;
  logic [11:0]        batt = 12'hB00;
  logic signed [12:0] error;
  logic               not_pedaling;
  logic [11:0]        target_curr;

  int k      = 0;
  int tper   = 64;
  int passes = 0;
  int fails  = 0;
  int total  = 0;
  bit cad_en = 1'b0;

  always #5 clk = ~clk;

  pid_error_gen #(.FAST_SIM(1)) dut (
    .clk(clk), .rst(rst), .cadence_raw(cadence_raw),
    .torque(torque), .torque_vld(torque_vld),
    .curr(curr), .curr_vld(curr_vld),
    .scale(scale), .batt(batt),
    .error(error), .not_pedaling(not_pedaling), .target_curr(target_curr)
  );

  // k counts posedges since reset release; inputs are set for posedge k+1.
  // The cadence wave rises when (p+2)%256==0, so its edge is counted at posedges
  // that are multiples of 256, including every window end.
  task automatic tick();
    int p;
    p = k + 1;
    cadence_raw = cad_en && (((p + 2) % 256) < 128);
    torque_vld  = ((p % tper) == 0);
    curr_vld    = ((p % 64) == 0);
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic run_to(input int n);
    while (k < n) tick();
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    torque = 12'h780;
    curr   = 12'h040;
    scale  = 3'd4;
    cad_en = 1'b1;
    tper   = 1;
    k      = 120;
    repeat (10) tick();
    chk("rst_error", 32'(error), 0);
    chk("rst_target", 32'(target_curr), 0);
    chk("rst_np", 32'(not_pedaling), 1);

    rst  = 1'b0;
    k    = 0;
    tper = 64;
    run_to(2000);
    chk("win1_np_mid", 32'(not_pedaling), 1);
    run_to(4096);
    chk("win1_np_end", 32'(not_pedaling), 1);
    run_to(4097);
    chk("win1_np_after", 32'(not_pedaling), 0);

    run_to(12200);
    chk("ped_target", 32'(target_curr), 256);
    chk("ped_error", 32'(error), 192);
    chk("ped_np", 32'(not_pedaling), 0);

    curr = 12'h180;
    run_to(14000);
    chk("curr_hi_error", 32'(error), -128);
    chk("curr_hi_target", 32'(target_curr), 256);

    cad_en = 1'b0;
    run_to(16500);
    chk("rate6_target", 32'(target_curr), 96);
    chk("rate6_error", 32'(error), -288);
    chk("rate6_np", 32'(not_pedaling), 0);
    run_to(20480);
    chk("stop_np_hold", 32'(not_pedaling), 0);
    run_to(20483);
    chk("stop_np", 32'(not_pedaling), 1);
    chk("stop_target", 32'(target_curr), 0);
    chk("stop_error", 32'(error), -384);

    run_to(20700);
    cad_en = 1'b1;
    run_to(24500);
    chk("restart_target0", 32'(target_curr), 0);
    run_to(24578);
    chk("winend_edge_target", 32'(target_curr), 256);
    chk("winend_edge_np", 32'(not_pedaling), 0);
    run_to(24600);
    chk("winend_edge_error", 32'(error), -128);

    torque = 12'h380;
    tper   = 4;
    run_to(25700);
    chk("deadband_target", 32'(target_curr), 0);
    chk("deadband_np", 32'(not_pedaling), 0);
    chk("deadband_error", 32'(error), -384);

    torque = 12'h480;
    run_to(26600);
    chk("t480_target", 32'(target_curr), 64);
    chk("t480_error", 32'(error), -320);
    scale = 3'd0;
    run_to(26605);
    chk("scale0_target", 32'(target_curr), 0);
    scale = 3'd7;
    run_to(26610);
    chk("scale7_target", 32'(target_curr), 112);

`ifdef LOW_BATT_CUTOFF_EN
    scale  = 3'd4;
    torque = 12'h780;
    run_to(27400);
    chk("batt_ok_target", 32'(target_curr), 256);
    batt = 12'hA90;
    run_to(27405);
    chk("batt_low_target", 32'(target_curr), 0);
    batt = 12'hA9C;
    run_to(27410);
    chk("batt_hyst_low", 32'(target_curr), 0);
    batt = 12'hAA0;
    run_to(27415);
    chk("batt_release", 32'(target_curr), 256);
    batt = 12'hA9C;
    run_to(27420);
    chk("batt_hyst_high", 32'(target_curr), 256);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
